// File: rtl/mips_bus_arbiter_if.sv
// rtl/mips_bus_arbiter_if.sv - Avalon-style memory port shared by the CPU requesters and the external bus.
interface mips_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        rvalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, rvalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, rvalid
  );
endinterface

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - Two-requester (fetch/load-store) arbiter for the CPU memory bus.
module mips_bus_arbiter #(
  parameter int unsigned PRIORITY   = 0,
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic               clk,
  input  logic               reset,
  mips_bus_arbiter_if.slave  i_port,
  mips_bus_arbiter_if.slave  d_port,
  mips_bus_arbiter_if.master bus,
  output logic               timeout
);
  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_e;
  typedef enum logic {PORT_I, PORT_D} port_e;

  state_e        state_q, state_d;
  port_e         rr_next_q, rr_next_d;
  port_e         rd_owner_q, rd_owner_d;
  logic          rvalid_q, rvalid_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;

  logic i_req, d_req, owner_req, accept;
  logic unused_inputs;

  assign i_req = i_port.read;
  assign d_req = d_port.read | d_port.write;

  // The fetch port is read-only and the bus never reports rvalid back to us.
  assign unused_inputs = ^{bus.rvalid, i_port.write, i_port.writedata, i_port.byteenable};

  always_comb begin
    bus.address        = '0;
    bus.read           = 1'b0;
    bus.write          = 1'b0;
    bus.writedata      = '0;
    bus.byteenable     = '0;
    i_port.waitrequest = 1'b1;
    d_port.waitrequest = 1'b1;
    owner_req          = 1'b0;
    case (state_q)
      OWN_I: begin
        bus.address        = i_port.address;
        bus.read           = i_port.read;
        bus.byteenable     = 4'hF;
        i_port.waitrequest = bus.waitrequest;
        owner_req          = i_req;
      end
      OWN_D: begin
        bus.address        = d_port.address;
        bus.read           = d_port.read;
        bus.write          = d_port.write & ~d_port.read;
        bus.writedata      = d_port.writedata;
        bus.byteenable     = d_port.byteenable;
        d_port.waitrequest = bus.waitrequest;
        owner_req          = d_req;
      end
      default: ;
    endcase
  end

  assign accept = (state_q != IDLE) && owner_req && !bus.waitrequest;

  always_comb begin
    state_d    = state_q;
    rr_next_d  = rr_next_q;
    rd_owner_d = rd_owner_q;
    rvalid_d   = 1'b0;
    wait_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req)
          state_d = (PRIORITY != 0 || rr_next_q == PORT_D) ? OWN_D : OWN_I;
        else if (d_req)
          state_d = OWN_D;
        else if (i_req)
          state_d = OWN_I;
      end
      default: begin
        if (accept) begin
          state_d    = IDLE;
          rr_next_d  = (state_q == OWN_I) ? PORT_D : PORT_I;
          rd_owner_d = (state_q == OWN_I) ? PORT_I : PORT_D;
          rvalid_d   = bus.read;
        end else if (!owner_req) begin
          // Owner withdrew before acceptance: release the bus without a transfer.
          state_d = IDLE;
        end else begin
          wait_cnt_d = (wait_cnt_q == LIMIT) ? wait_cnt_q : wait_cnt_q + CW'(1);
        end
      end
    endcase
    timeout_d = timeout_q | ((WAIT_LIMIT != 0) && (wait_cnt_d == LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_next_q  <= PORT_D;
      rd_owner_q <= PORT_I;
      rvalid_q   <= 1'b0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_next_q  <= rr_next_d;
      rd_owner_q <= rd_owner_d;
      rvalid_q   <= rvalid_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign i_port.readdata = bus.readdata;
  assign d_port.readdata = bus.readdata;
  assign i_port.rvalid   = rvalid_q && (rd_owner_q == PORT_I);
  assign d_port.rvalid   = rvalid_q && (rd_owner_q == PORT_D);
  assign timeout         = timeout_q;
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - Directed bench for mips_bus_arbiter with a read-return scoreboard.
module tb_mips_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] i_addr = '0, d_addr = '0, d_wd = '0;
  logic        i_rd = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [3:0]  d_be = '0;
  logic        bus_wait = 1'b0;
  logic [31:0] rdata0, rdata1;
  logic        timeout0, timeout1;
  logic        mon_sel = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  mips_bus_arbiter_if i0(), d0(), b0(), i1(), d1(), b1();

  assign i0.address = i_addr;  assign i1.address = i_addr;
  assign i0.read = i_rd;       assign i1.read = i_rd;
  assign i0.write = 1'b0;      assign i1.write = 1'b0;
  assign i0.writedata = '0;    assign i1.writedata = '0;
  assign i0.byteenable = '0;   assign i1.byteenable = '0;
  assign d0.address = d_addr;  assign d1.address = d_addr;
  assign d0.read = d_rd;       assign d1.read = d_rd;
  assign d0.write = d_wr;      assign d1.write = d_wr;
  assign d0.writedata = d_wd;  assign d1.writedata = d_wd;
  assign d0.byteenable = d_be; assign d1.byteenable = d_be;
  assign b0.waitrequest = bus_wait; assign b1.waitrequest = bus_wait;
  assign b0.readdata = rdata0; assign b1.readdata = rdata1;
  assign b0.rvalid = 1'b0;     assign b1.rvalid = 1'b0;

  mips_bus_arbiter #(.PRIORITY(0), .WAIT_LIMIT(64)) dut0 (
    .clk(clk), .reset(reset), .i_port(i0), .d_port(d0), .bus(b0), .timeout(timeout0)
  );

  mips_bus_arbiter #(.PRIORITY(1), .WAIT_LIMIT(3)) dut1 (
    .clk(clk), .reset(reset), .i_port(i1), .d_port(d1), .bus(b1), .timeout(timeout1)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h3C08_BFC0 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory responder: data one cycle after an accepted read, junk otherwise.
  always @(posedge clk) begin
    rdata0 <= (b0.read && !b0.waitrequest) ? mem_f(b0.address) : 32'hDEAD_BEEF;
    rdata1 <= (b1.read && !b1.waitrequest) ? mem_f(b1.address) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic is_d, input logic [31:0] a);
    exp_t e;
    e.is_d = is_d;
    e.data = mem_f(a);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic iv, dv;
    logic [31:0] rd;
    iv = mon_sel ? i1.rvalid : i0.rvalid;
    dv = mon_sel ? d1.rvalid : d0.rvalid;
    rd = dv ? (mon_sel ? d1.readdata : d0.readdata) : (mon_sel ? i1.readdata : i0.readdata);
    if (iv || dv) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, iv, dv}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rv_both", {31'd0, iv & dv}, 32'd0);
        chk("rv_port", {31'd0, dv}, {31'd0, mon_e.is_d});
        chk("rv_data", rd, mon_e.data);
      end
    end
  end

  initial begin
    // Reset held two cycles
    cyc(); cyc(); #1;
    chk("rst_read", {31'd0, b0.read}, 32'd0);
    chk("rst_write", {31'd0, b0.write}, 32'd0);
    chk("rst_addr", b0.address, 32'd0);
    chk("rst_be", {28'd0, b0.byteenable}, 32'd0);
    chk("rst_i_wait", {31'd0, i0.waitrequest}, 32'd1);
    chk("rst_d_wait", {31'd0, d0.waitrequest}, 32'd1);
    chk("rst_timeout", {31'd0, timeout0}, 32'd0);

    // Single fetch
    reset = 1'b0; i_rd = 1'b1; i_addr = 32'hBFC0_0000; push(1'b0, i_addr);
    cyc(); #1;
    chk("f_read", {31'd0, b0.read}, 32'd1);
    chk("f_addr", b0.address, 32'hBFC0_0000);
    chk("f_be", {28'd0, b0.byteenable}, 32'hF);
    chk("f_i_wait", {31'd0, i0.waitrequest}, 32'd0);
    chk("f_d_wait", {31'd0, d0.waitrequest}, 32'd1);
    cyc(); i_rd = 1'b0; #1;
    chk("f_rvalid", {31'd0, i0.rvalid}, 32'd1);
    chk("f_rdata", i0.readdata, 32'h3C08_BFC0);
    chk("f_idle_read", {31'd0, b0.read}, 32'd0);

    // Round-robin collisions
    reset = 1'b1; cyc(); reset = 1'b0;
    i_rd = 1'b1; i_addr = 32'h0000_1000; d_rd = 1'b1; d_addr = 32'h0000_2000; d_be = 4'hF;
    push(1'b1, d_addr);
    cyc(); #1;
    chk("rr1_addr", b0.address, 32'h0000_2000);
    chk("rr1_d_wait", {31'd0, d0.waitrequest}, 32'd0);
    chk("rr1_i_wait", {31'd0, i0.waitrequest}, 32'd1);
    cyc(); d_addr = 32'h0000_2004; push(1'b0, i_addr); #1;
    chk("rr1_d_rvalid", {31'd0, d0.rvalid}, 32'd1);
    chk("rr_idle_read", {31'd0, b0.read}, 32'd0);
    cyc(); #1;
    chk("rr2_addr", b0.address, 32'h0000_1000);
    chk("rr2_i_wait", {31'd0, i0.waitrequest}, 32'd0);
    chk("rr2_d_wait", {31'd0, d0.waitrequest}, 32'd1);
    cyc(); i_rd = 1'b0; push(1'b1, d_addr); #1;
    chk("rr2_i_rvalid", {31'd0, i0.rvalid}, 32'd1);
    cyc(); #1;
    chk("rr3_addr", b0.address, 32'h0000_2004);
    chk("rr3_d_wait", {31'd0, d0.waitrequest}, 32'd0);
    cyc(); d_rd = 1'b0; #1;
    chk("rr3_d_rvalid", {31'd0, d0.rvalid}, 32'd1);
    cyc(); #1;
    chk("rr_end_read", {31'd0, b0.read}, 32'd0);

    // Fixed priority: D wins every collision
    mon_sel = 1'b1;
    reset = 1'b1; cyc(); reset = 1'b0;
    i_rd = 1'b1; i_addr = 32'h0000_3000; d_rd = 1'b1; d_addr = 32'h0000_4000;
    push(1'b1, d_addr);
    cyc(); #1;
    chk("pr1_addr", b1.address, 32'h0000_4000);
    chk("pr1_i_wait", {31'd0, i1.waitrequest}, 32'd1);
    cyc(); d_addr = 32'h0000_4004; push(1'b1, d_addr); #1;
    chk("pr1_d_rvalid", {31'd0, d1.rvalid}, 32'd1);
    cyc(); #1;
    chk("pr2_addr", b1.address, 32'h0000_4004);
    chk("pr2_d_wait", {31'd0, d1.waitrequest}, 32'd0);
    chk("pr2_i_wait", {31'd0, i1.waitrequest}, 32'd1);
    cyc(); d_rd = 1'b0; push(1'b0, i_addr); #1;
    chk("pr2_d_rvalid", {31'd0, d1.rvalid}, 32'd1);
    cyc(); #1;
    chk("pr3_addr", b1.address, 32'h0000_3000);
    chk("pr3_i_wait", {31'd0, i1.waitrequest}, 32'd0);
    cyc(); i_rd = 1'b0; #1;
    chk("pr3_i_rvalid", {31'd0, i1.rvalid}, 32'd1);
    cyc(); #1;
    chk("pr_end_read", {31'd0, b1.read}, 32'd0);
    mon_sel = 1'b0;

    // Stalled store; dut1 has WAIT_LIMIT=3
    reset = 1'b1; cyc(); reset = 1'b0;
    d_wr = 1'b1; d_addr = 32'h0000_5000; d_wd = 32'h0000_000F; d_be = 4'hF; bus_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("st_write", {31'd0, b0.write}, 32'd1);
      chk("st_addr", b0.address, 32'h0000_5000);
      chk("st_wdata", b0.writedata, 32'h0000_000F);
      chk("st_be", {28'd0, b0.byteenable}, 32'hF);
      chk("st_d_wait", {31'd0, d0.waitrequest}, 32'd1);
      chk("st_to1_early", {31'd0, timeout1}, 32'd0);
    end
    cyc(); bus_wait = 1'b0; #1;
    chk("st_acc_write", {31'd0, b0.write}, 32'd1);
    chk("st_acc_d_wait", {31'd0, d0.waitrequest}, 32'd0);
    chk("st_to1_set", {31'd0, timeout1}, 32'd1);
    chk("st_to0_clear", {31'd0, timeout0}, 32'd0);
    cyc(); d_wr = 1'b0; #1;
    chk("st_no_rvalid", {31'd0, d0.rvalid}, 32'd0);
    chk("st_idle_write", {31'd0, b0.write}, 32'd0);
    cyc(); #1;
    chk("st_to1_sticky", {31'd0, timeout1}, 32'd1);

    // Reset during a pending load
    d_rd = 1'b1; d_addr = 32'h0000_6000; bus_wait = 1'b1;
    cyc(); #1;
    chk("rl_read", {31'd0, b0.read}, 32'd1);
    chk("rl_d_wait", {31'd0, d0.waitrequest}, 32'd1);
    reset = 1'b1; bus_wait = 1'b0;
    cyc(); reset = 1'b0; #1;
    chk("rl_idle_read", {31'd0, b0.read}, 32'd0);
    chk("rl_idle_d_wait", {31'd0, d0.waitrequest}, 32'd1);
    chk("rl_rvalid0", {31'd0, d0.rvalid}, 32'd0);
    chk("rl_to1_cleared", {31'd0, timeout1}, 32'd0);
    d_rd = 1'b0;
    cyc(); #1;
    chk("rl_rvalid1", {31'd0, d0.rvalid}, 32'd0);

    cyc();
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
